func_gen_ctrl: RTL

FUNC_GEN_CTRL -- requirements
Module: func_gen_ctrl

---
 rtl/func_gen_ctrl_pkg.sv | 17 +
 rtl/func_gen_ctrl_if.sv | 25 ++
 rtl/func_gen_ctrl_tick_prescaler.sv | 22 ++
 rtl/func_gen_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/func_gen_ctrl_pkg.sv
// func_gen_ctrl_pkg: controller state encoding, waveform codes and the sample scaler.
package func_gen_ctrl_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, GRST} state_t;
    localparam logic [1:0] WAVE_SINE = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI = 2'd2;
    localparam logic [1:0] WAVE_SAW = 2'd3;
    localparam logic [7:0] MIDSCALE = 8'd128;

    // Centre on midscale, attenuate arithmetically, re-bias; the low 8 bits always land in 0..255.
    function automatic logic [7:0] scale_sample(input logic [7:0] s, input logic [1:0] sh);
        logic signed [8:0] c;
        c = $signed({1'b0, s}) - 9'sd128;
        c = c >>> sh;
        return c[7:0] + MIDSCALE;
    endfunction
endpackage

// File: rtl/func_gen_ctrl_if.sv
// func_gen_ctrl_if: request handshake, generator samples and control outputs of the controller.
interface func_gen_ctrl_if #(parameter int DIV_W = 8);
    logic             sel_valid;
    logic [1:0]       sel_wave;
    logic             sel_ready;
    logic [DIV_W-1:0] freq_div;
    logic [1:0]       amp_shift;
    logic [7:0]       sin_in;
    logic [7:0]       sq_in;
    logic [7:0]       tri_in;
    logic [7:0]       saw_in;
    logic             tick;
    logic             gen_rst;
    logic [1:0]       wave_sel;
    logic [7:0]       wave_out;

    modport master (
        output sel_valid, sel_wave, freq_div, amp_shift, sin_in, sq_in, tri_in, saw_in,
        input  sel_ready, tick, gen_rst, wave_sel, wave_out
    );
    modport slave (
        input  sel_valid, sel_wave, freq_div, amp_shift, sin_in, sq_in, tri_in, saw_in,
        output sel_ready, tick, gen_rst, wave_sel, wave_out
    );
endinterface

// File: rtl/func_gen_ctrl_tick_prescaler.sv
// tick_prescaler: one-cycle tick every freq_div+1 enabled cycles; held at zero while disabled.
module tick_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] freq_div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    // >= rather than == so a freq_div lowered below the count ticks straight away.
    always_comb begin
        tick = en && (cnt_q >= freq_div);
        cnt_d = (!en || tick) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end
endmodule

// File: rtl/func_gen_ctrl.sv
// func_gen_ctrl: waveform selector that drains to a rising midscale crossing before
// switching, then pulses gen_rst so the new generator starts in phase.
module func_gen_ctrl
    import func_gen_ctrl_pkg::*;
#(
    parameter int DIV_W      = 8,
    parameter int TIMEOUT    = 1024,
    parameter int RST_CYCLES = 2
) (
    input logic           clk,
    input logic           rst,
    func_gen_ctrl_if.slave bus
);
    localparam int DW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(RST_CYCLES + 1);

    state_t          state_q, state_d;
    logic [GW-1:0]   grst_cnt_q, grst_cnt_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [1:0]      wave_sel_q, wave_sel_d;
    logic [1:0]      pending_q, pending_d;
    logic            prev_msb_q, prev_msb_d;
    logic [7:0]      wave_out_q, wave_out_d;
    logic [7:0]      sample;
    logic            tick;
    logic            sel_ready;
    logic            crossing;

    tick_prescaler #(.DIV_W(DIV_W)) u_presc (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q != GRST && !rst),
        .freq_div (bus.freq_div),
        .tick     (tick)
    );

    assign sel_ready    = state_q == RUN && !rst;
    assign bus.sel_ready = sel_ready;
    assign bus.tick     = tick;
    assign bus.gen_rst  = state_q == GRST || rst;
    assign bus.wave_sel = wave_sel_q;
    assign bus.wave_out = wave_out_q;

    always_comb begin
        sample = (wave_sel_q == WAVE_SINE)   ? bus.sin_in :
                 (wave_sel_q == WAVE_SQUARE) ? bus.sq_in  :
                 (wave_sel_q == WAVE_TRI)    ? bus.tri_in : bus.saw_in;
        crossing = !prev_msb_q && sample[7];
        state_d = state_q;
        grst_cnt_d = grst_cnt_q;
        drain_cnt_d = drain_cnt_q;
        wave_sel_d = wave_sel_q;
        pending_d = pending_q;
        prev_msb_d = tick ? sample[7] : prev_msb_q;
        if (state_q == RUN) begin
            if (bus.sel_valid && sel_ready && bus.sel_wave != wave_sel_q) begin
                state_d = DRAIN;
                pending_d = bus.sel_wave;
                drain_cnt_d = '0;
            end
        end else if (state_q == DRAIN) begin
            if (tick && (crossing || drain_cnt_q == DW'(TIMEOUT - 1))) begin
                state_d = GRST;
                grst_cnt_d = '0;
                wave_sel_d = pending_q;
            end else if (tick) begin
                drain_cnt_d = drain_cnt_q + 1'b1;
            end
        end else begin
            state_d = (grst_cnt_q == GW'(RST_CYCLES - 1)) ? RUN : GRST;
            grst_cnt_d = (grst_cnt_q == GW'(RST_CYCLES - 1)) ? grst_cnt_q : grst_cnt_q + 1'b1;
        end
        // Parking at midscale on GRST entry keeps the output centred for the whole reset pulse.
        wave_out_d = (state_d == GRST) ? MIDSCALE :
                     tick ? scale_sample(sample, bus.amp_shift) : wave_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= GRST;
            grst_cnt_q  <= '0;
            drain_cnt_q <= '0;
            wave_sel_q  <= WAVE_SINE;
            pending_q   <= WAVE_SINE;
            prev_msb_q  <= 1'b0;
            wave_out_q  <= MIDSCALE;
        end else begin
            state_q     <= state_d;
            grst_cnt_q  <= grst_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            wave_sel_q  <= wave_sel_d;
            pending_q   <= pending_d;
            prev_msb_q  <= prev_msb_d;
            wave_out_q  <= wave_out_d;
        end
    end
endmodule
